// File: rtl/cache_dm_wt.sv
// Direct-mapped write-through, no-write-allocate cache with burst line refill.
// Define CACHE_STATS_EN to enable the saturating read hit/miss counters.
module cache_dm_wt #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ready,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int IW    = $clog2(LINES);
  localparam int OBITS = $clog2(WORDS_PER_LINE);
  localparam int OW    = (OBITS > 0) ? OBITS : 1;
  localparam int OB    = 2 + OBITS;
  localparam int TW    = ADDR_W - OB - IW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_RESPOND,
    S_WRITE
  } state_t;

  state_t            r_state;
  logic [LINES-1:0]  r_valid;
  logic [TW-1:0]     r_tags [LINES];
  logic [DATA_W-1:0] r_data [LINES][WORDS_PER_LINE];

  logic [TW-1:0]     r_tag;
  logic [IW-1:0]     r_idx;
  logic [OW-1:0]     r_off;
  logic [OW-1:0]     r_k;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [TW-1:0]     w_tag;
  logic [IW-1:0]     w_idx;
  logic [OW-1:0]     w_off;
  logic [OW-1:0]     w_k_next;
  logic              w_hit;
  logic              w_wr_hit;
  logic              w_last;
  logic              w_fill;
  logic              w_unused;

  assign w_idx    = cpu_addr[OB+IW-1:OB];
  assign w_tag    = cpu_addr[ADDR_W-1:OB+IW];
  assign w_unused = ^cpu_addr[1:0];

  generate
    if (OBITS > 0) begin : g_off
      assign w_off = cpu_addr[OB-1:2];
    end else begin : g_no_off
      assign w_off = 1'b0;
    end
  endgenerate

  function automatic logic [ADDR_W-1:0] f_addr(
    input logic [TW-1:0] t,
    input logic [IW-1:0] i,
    input logic [OW-1:0] k
  );
    return (ADDR_W'(t) << (OB + IW))
         | (ADDR_W'(i) << OB)
         | (ADDR_W'(k) << 2);
  endfunction

  assign w_hit = (r_state == S_IDLE) && cpu_req && !cpu_we
              && r_valid[w_idx] && (r_tags[w_idx] == w_tag);

  // Write hit is judged on the captured coordinates, not the live bus.
  assign w_wr_hit = r_valid[r_idx] && (r_tags[r_idx] == r_tag);
  assign w_k_next = r_k + 1'b1;
  assign w_last   = (r_k == OW'(WORDS_PER_LINE - 1));
  assign w_fill   = !reset && (r_state == S_REFILL) && mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_k         <= '0;
      r_tag       <= '0;
      r_idx       <= '0;
      r_off       <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cpu_req && !w_hit) begin
            r_tag <= w_tag;
            r_idx <= w_idx;
            r_off <= w_off;
            r_k   <= '0;
            if (cpu_we) begin
              r_state     <= S_WRITE;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
              r_mem_wdata <= cpu_wdata;
            end else begin
              r_state    <= S_REFILL;
              r_mem_read <= 1'b1;
              r_mem_addr <= f_addr(w_tag, w_idx, '0);
            end
          end
        end
        S_REFILL: begin
          if (mem_ready) begin
            r_k <= w_k_next;
            if (w_last) begin
              r_valid[r_idx] <= 1'b1;
              r_mem_read     <= 1'b0;
              r_state        <= S_RESPOND;
            end else begin
              r_mem_addr <= f_addr(r_tag, r_idx, w_k_next);
            end
          end
        end
        S_RESPOND: begin
          r_state <= S_IDLE;
        end
        S_WRITE: begin
          if (mem_ready) begin
            r_mem_write <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity alone gates their use.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[r_idx][r_k] <= mem_read_data;
    end
    if (w_fill && w_last) begin
      r_tags[r_idx] <= r_tag;
    end
    if (!reset && (r_state == S_WRITE) && mem_ready && w_wr_hit) begin
      r_data[r_idx][r_off] <= r_mem_wdata;
    end
  end

  always_comb begin
    cpu_rdata = '0;
    if (w_hit) begin
      cpu_rdata = r_data[w_idx][w_off];
    end else if (r_state == S_RESPOND) begin
      cpu_rdata = r_data[r_idx][r_off];
    end
  end

  assign cpu_ready = w_hit
                  || (r_state == S_RESPOND)
                  || ((r_state == S_WRITE) && mem_ready);

  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        w_miss;

  assign w_miss = (r_state == S_IDLE) && cpu_req && !cpu_we && !w_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_dm_wt.sv
// Directed bench for cache_dm_wt: refill order, hits, write-through,
// conflicts, zero-latency memory, mid-refill reset and the stats counters.
module tb_cache_dm_wt;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  cache_dm_wt #(
    .ADDR_W(32),
    .DATA_W(32),
    .LINES(16),
    .WORDS_PER_LINE(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_ready(mem_ready),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:511];
  int          lat = 2;
  int          cnt = 0;
  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];
  bit          q_we [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          r_both = 0;
  bit          r_unstable = 0;
  bit          mon_pend = 0;
  logic [31:0] mon_addr;
  logic [31:0] mon_wd;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + 32'(i * 4);
    mem[64] = 32'hA0;
    mem[65] = 32'hA1;
    mem[66] = 32'hA2;
    mem[67] = 32'hA3;
  end

  // Memory responder: answers after `lat` idle negedges, logs each completion.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (mem_read || mem_write) begin
      if (cnt >= lat) begin
        mem_ready = 1'b1;
        mem_read_data = mem[mem_addr[10:2]];
        if (mem_write) mem[mem_addr[10:2]] = mem_write_data;
        q_addr.push_back(mem_addr);
        q_data.push_back(mem_write_data);
        q_we.push_back(mem_write);
        cnt = 0;
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  always @(posedge clk) begin
    if (mem_read && mem_write) r_both = 1'b1;
    if ((mem_read || mem_write) && mon_pend &&
        (mem_addr !== mon_addr ||
         (mem_write && mem_write_data !== mon_wd)))
      r_unstable = 1'b1;
    mon_pend = (mem_read || mem_write) && !mem_ready && !reset;
    mon_addr = mem_addr;
    mon_wd   = mem_write_data;
  end

  task automatic access(input bit we, input logic [31:0] a,
                        input logic [31:0] wd,
                        output logic [31:0] rd, output int cyc);
    bit done;
    done = 0;
    cyc = 0;
    rd = '0;
    q_addr.delete();
    q_data.delete();
    q_we.delete();
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = wd;
    while (!done && cyc < 300) begin
      #1;
      cyc++;
      if (cpu_ready) begin
        done = 1;
        rd = cpu_rdata;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    cpu_req = 1'b0;
    cpu_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({cpu_ready, mem_read, mem_write} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b want 000",
               {cpu_ready, mem_read, mem_write});
    end
    n_cmp++;
    if ({mem_addr, mem_write_data, cpu_rdata} !== 96'h0) begin
      n_bad++;
      $display("FAIL reset_data got %h %h %h want 0",
               mem_addr, mem_write_data, cpu_rdata);
    end
    n_cmp++;
    if ({hit_count, miss_count} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_counters got %h %h want 0", hit_count, miss_count);
    end
    @(negedge clk);
  endtask

  task automatic test_refill();
    logic [31:0] rd;
    int cyc;
    access(1'b0, 32'h104, '0, rd, cyc);
    n_cmp++;
    if (q_addr.size() != 4) begin
      n_bad++;
      $display("FAIL refill_count got %0d want 4", q_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (q_addr[i] !== 32'h100 + 32'(i * 4) || q_we[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL refill_addr[%0d] got %h want %h",
                 i, q_addr[i], 32'h100 + 32'(i * 4));
      end
    end
    n_cmp++;
    if (rd !== 32'hA1 || cyc != 14) begin
      n_bad++;
      $display("FAIL refill_resp got %h/%0d want a1/14", rd, cyc);
    end
    access(1'b0, 32'h10C, '0, rd, cyc);
    n_cmp++;
    if (rd !== 32'hA3 || cyc != 1 || q_addr.size() != 0) begin
      n_bad++;
      $display("FAIL read_hit got %h/%0d/%0d want a3/1/0",
               rd, cyc, q_addr.size());
    end
  endtask

  task automatic test_conflict();
    logic [31:0] rd;
    int cyc;
    access(1'b0, 32'h204, '0, rd, cyc);
    n_cmp++;
    if (q_addr.size() != 4 || q_addr[0] !== 32'h200 ||
        q_addr[3] !== 32'h20C || rd !== 32'h1000_0204) begin
      n_bad++;
      $display("FAIL conflict_fill got n=%0d %h %h rd=%h want 4 200 20c 10000204",
               q_addr.size(), q_addr[0], q_addr[3], rd);
    end
    access(1'b0, 32'h104, '0, rd, cyc);
    n_cmp++;
    if (q_addr.size() != 4 || q_addr[0] !== 32'h100 || rd !== 32'hA1) begin
      n_bad++;
      $display("FAIL conflict_back got n=%0d %h rd=%h want 4 100 a1",
               q_addr.size(), q_addr[0], rd);
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd;
    int cyc;
    access(1'b1, 32'h108, 32'hDEAD_BEEF, rd, cyc);
    n_cmp++;
    if (q_addr.size() != 1 || q_we[0] !== 1'b1 || q_addr[0] !== 32'h108 ||
        q_data[0] !== 32'hDEAD_BEEF || cyc != 4) begin
      n_bad++;
      $display("FAIL write_hit_bus got n=%0d %h %h cyc=%0d want 1 108 deadbeef 4",
               q_addr.size(), q_addr[0], q_data[0], cyc);
    end
    access(1'b0, 32'h108, '0, rd, cyc);
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF || cyc != 1 || q_addr.size() != 0) begin
      n_bad++;
      $display("FAIL write_hit_read got %h/%0d/%0d want deadbeef/1/0",
               rd, cyc, q_addr.size());
    end
  endtask

  task automatic test_write_miss();
    logic [31:0] rd;
    int cyc;
    access(1'b1, 32'h300, 32'h1234_5678, rd, cyc);
    n_cmp++;
    if (q_addr.size() != 1 || q_we[0] !== 1'b1 || q_addr[0] !== 32'h300 ||
        q_data[0] !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL write_miss_bus got n=%0d %h %h want 1 300 12345678",
               q_addr.size(), q_addr[0], q_data[0]);
    end
    access(1'b0, 32'h300, '0, rd, cyc);
    n_cmp++;
    if (q_addr.size() != 4 || q_addr[0] !== 32'h300 ||
        rd !== 32'h1234_5678 || cyc != 14) begin
      n_bad++;
      $display("FAIL write_miss_read got n=%0d %h rd=%h cyc=%0d want 4 300 12345678 14",
               q_addr.size(), q_addr[0], rd, cyc);
    end
  endtask

  task automatic test_zero_latency();
    logic [31:0] rd;
    int cyc;
    lat = 0;
    access(1'b0, 32'h504, '0, rd, cyc);
    n_cmp++;
    if (q_addr.size() != 4 || q_addr[3] !== 32'h50C ||
        rd !== 32'h1000_0504 || cyc != 6) begin
      n_bad++;
      $display("FAIL zlat_read got n=%0d %h rd=%h cyc=%0d want 4 50c 10000504 6",
               q_addr.size(), q_addr[3], rd, cyc);
    end
    access(1'b1, 32'h508, 32'h55AA, rd, cyc);
    n_cmp++;
    if (cyc != 2 || q_addr.size() != 1) begin
      n_bad++;
      $display("FAIL zlat_write got cyc=%0d n=%0d want 2 1", cyc, q_addr.size());
    end
    access(1'b0, 32'h508, '0, rd, cyc);
    n_cmp++;
    if (rd !== 32'h55AA || cyc != 1) begin
      n_bad++;
      $display("FAIL zlat_hit got %h/%0d want 55aa/1", rd, cyc);
    end
    lat = 2;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int cyc;
    access(1'b0, 32'h110, '0, rd, cyc);
    q_addr.delete();
    q_data.delete();
    q_we.delete();
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h404;
    for (int i = 0; i < 100 && q_addr.size() < 2; i++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    n_cmp++;
    if (mem_read !== 1'b1 || q_addr.size() != 2) begin
      n_bad++;
      $display("FAIL mid_pending got rd=%b n=%0d want 1 2",
               mem_read, q_addr.size());
    end
    reset = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_read, mem_write, cpu_ready} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_abort got %b want 000",
               {mem_read, mem_write, cpu_ready});
    end
    @(negedge clk);
    access(1'b0, 32'h110, '0, rd, cyc);
    n_cmp++;
    if (q_addr.size() != 4 || q_addr[0] !== 32'h110 || rd !== 32'h1000_0110) begin
      n_bad++;
      $display("FAIL mid_invalidated got n=%0d %h rd=%h want 4 110 10000110",
               q_addr.size(), q_addr[0], rd);
    end
    access(1'b0, 32'h104, '0, rd, cyc);
    n_cmp++;
    if (q_addr.size() != 4 || q_addr[0] !== 32'h100 ||
        q_addr[3] !== 32'h10C || rd !== 32'hA1) begin
      n_bad++;
      $display("FAIL mid_refill got n=%0d %h %h rd=%h want 4 100 10c a1",
               q_addr.size(), q_addr[0], q_addr[3], rd);
    end
  endtask

  task automatic test_stats();
    logic [31:0] rd;
    int cyc;
    do_reset();
    access(1'b0, 32'h100, '0, rd, cyc);
    access(1'b0, 32'h104, '0, rd, cyc);
    access(1'b0, 32'h108, '0, rd, cyc);
    access(1'b0, 32'h200, '0, rd, cyc);
    access(1'b0, 32'h204, '0, rd, cyc);
    access(1'b0, 32'h300, '0, rd, cyc);
    access(1'b0, 32'h304, '0, rd, cyc);
    access(1'b0, 32'h308, '0, rd, cyc);
    access(1'b1, 32'h308, 32'h77, rd, cyc);
`ifdef CACHE_STATS_EN
    n_cmp++;
    if (miss_count !== 32'd3 || hit_count !== 32'd5) begin
      n_bad++;
      $display("FAIL stats_count got m=%0d h=%0d want 3 5",
               miss_count, hit_count);
    end
    force dut.r_hit_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_hit_cnt;
    access(1'b0, 32'h30C, '0, rd, cyc);
    n_cmp++;
    if (hit_count !== 32'hFFFF_FFFF || miss_count !== 32'd3) begin
      n_bad++;
      $display("FAIL stats_saturate got h=%h m=%0d want ffffffff 3",
               hit_count, miss_count);
    end
`else
    n_cmp++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_bad++;
      $display("FAIL stats_off got h=%h m=%h want 0 0", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_handshake();
    n_cmp++;
    if (r_both !== 1'b0) begin
      n_bad++;
      $display("FAIL hs_exclusive got %b want 0", r_both);
    end
    n_cmp++;
    if (r_unstable !== 1'b0) begin
      n_bad++;
      $display("FAIL hs_stable got %b want 0", r_unstable);
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_conflict();
    test_write_hit();
    test_write_miss();
    test_zero_latency();
    test_reset_mid();
    test_stats();
    test_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
